// File: rtl/multicycle_control.sv
// multicycle_control: IF/ID/EX/MEM/WB control FSM for the RV32 subset core.
// Option ILLEGAL_TRAP_EN: illegal opcodes trap into a sticky HALT state.
module multicycle_control #(
   parameter int unsigned DMEM_LATENCY = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instr,
   input  logic        Zero,
   output logic        PCSrc,
   output logic        ALUSrc,
   output logic        RegWrite,
   output logic        MemToReg,
   output logic [3:0]  ALUCtrl,
   output logic        loadPC,
   output logic        MemRead,
   output logic        MemWrite,
   output logic        illegal
);

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_SRL = 4'b1000;
   localparam logic [3:0] ALU_SLL = 4'b1001;
   localparam logic [3:0] ALU_SRA = 4'b1010;
   localparam logic [3:0] ALU_XOR = 4'b1101;

   localparam logic [3:0] LAT = 4'(DMEM_LATENCY);

   typedef enum logic [2:0] {
      S_IF,
      S_ID,
      S_EX,
      S_MEM,
      S_WB,
      S_HALT
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic [3:0] cnt;
   logic [3:0] cnt_nxt;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       b30;
   logic       is_r;
   logic       is_i;
   logic       is_lw;
   logic       is_sw;
   logic       is_beq;
   logic       is_bad;

   logic [3:0] alu_dec;
   logic       src_dec;
   logic [3:0] f3_alu;

   logic       pc_src;
   logic       reg_wr;
   logic       mem_to_reg;
   logic       load_pc;
   logic       mem_rd;
   logic       mem_wr;

   logic       unused_instr;

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign b30    = instr[30];

   assign is_r   = (opcode == OP_R);
   assign is_i   = (opcode == OP_I);
   assign is_lw  = (opcode == OP_LW);
   assign is_sw  = (opcode == OP_SW);
   assign is_beq = (opcode == OP_BEQ);
   assign is_bad = ~(is_r | is_i | is_lw | is_sw | is_beq);

   assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

   // funct3 table shared by R and I; bit 30 picks SUB/SRA variants
   always_comb begin
      f3_alu = ALU_ADD;
      case (funct3)
         3'b000:  f3_alu = (is_r && b30) ? ALU_SUB : ALU_ADD;
         3'b111:  f3_alu = ALU_AND;
         3'b110:  f3_alu = ALU_OR;
         3'b100:  f3_alu = ALU_XOR;
         3'b010:  f3_alu = ALU_SLT;
         3'b001:  f3_alu = ALU_SLL;
         3'b101:  f3_alu = b30 ? ALU_SRA : ALU_SRL;
         default: f3_alu = ALU_ADD;
      endcase
   end

   // ALU operation and operand select are pure opcode decode
   always_comb begin
      alu_dec = ALU_AND;
      src_dec = 1'b0;
      unique case (1'b1)
         is_r: begin
            alu_dec = f3_alu;
            src_dec = 1'b0;
         end
         is_i: begin
            alu_dec = f3_alu;
            src_dec = 1'b1;
         end
         is_lw, is_sw: begin
            alu_dec = ALU_ADD;
            src_dec = 1'b1;
         end
         is_beq: begin
            alu_dec = ALU_SUB;
            src_dec = 1'b0;
         end
         is_bad: begin
            alu_dec = ALU_AND;
            src_dec = 1'b0;
         end
      endcase
   end

   // next state, MEM wait count and per-state strobes
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      pc_src     = 1'b0;
      reg_wr     = 1'b0;
      mem_to_reg = 1'b0;
      load_pc    = 1'b0;
      mem_rd     = 1'b0;
      mem_wr     = 1'b0;
      unique case (state)
         S_IF: state_nxt = S_ID;
         S_ID: state_nxt = S_EX;
         S_EX: begin
            unique case (1'b1)
               is_r, is_i: state_nxt = S_WB;
               is_lw, is_sw: begin
                  state_nxt = S_MEM;
                  cnt_nxt   = LAT;
               end
               is_beq: begin
                  pc_src    = Zero;
                  load_pc   = 1'b1;
                  state_nxt = S_IF;
               end
               is_bad: begin
`ifdef ILLEGAL_TRAP_EN
                  state_nxt = S_HALT;
`else
                  load_pc   = 1'b1;
                  state_nxt = S_IF;
`endif
               end
            endcase
         end
         S_MEM: begin
            mem_rd     = is_lw;
            mem_to_reg = is_lw;
            if (cnt != 4'd0) begin
               cnt_nxt = cnt - 4'd1;
            end else begin
               mem_wr    = is_sw;
               load_pc   = is_sw;
               state_nxt = is_lw ? S_WB : S_IF;
            end
         end
         S_WB: begin
            reg_wr     = 1'b1;
            load_pc    = 1'b1;
            mem_to_reg = is_lw;
            state_nxt  = S_IF;
         end
         S_HALT: state_nxt = S_HALT;
         default: state_nxt = S_IF;
      endcase
   end

   // state and wait-counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IF;
         cnt   <= 4'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

`ifdef ILLEGAL_TRAP_EN
   logic illegal_q;

   // sticky flag, set on the way into HALT
   always_ff @(posedge clk) begin
      if (rst) begin
         illegal_q <= 1'b0;
      end else if (state == S_EX && is_bad) begin
         illegal_q <= 1'b1;
      end
   end

   assign illegal = illegal_q & ~rst;
`else
   assign illegal = 1'b0;
`endif

   assign PCSrc    = pc_src & ~rst;
   assign ALUSrc   = src_dec & ~rst;
   assign RegWrite = reg_wr & ~rst;
   assign MemToReg = mem_to_reg & ~rst;
   assign ALUCtrl  = rst ? 4'b0000 : alu_dec;
   assign loadPC   = load_pc & ~rst;
   assign MemRead  = mem_rd & ~rst;
   assign MemWrite = mem_wr & ~rst;

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: two DUTs (DMEM_LATENCY 0 and 2), one active at a time.
// Expected per-cycle output vectors are built from instruction class and latency.
module tb_multicycle_control;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_v   [2];
   logic [31:0] instr_v [2];
   logic        zero_v  [2];
   logic        pcsrc   [2];
   logic        alusrc  [2];
   logic        regwr   [2];
   logic        m2r     [2];
   logic [3:0]  aluctrl [2];
   logic        loadpc  [2];
   logic        memrd   [2];
   logic        memwr   [2];
   logic        illg    [2];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      multicycle_control #(.DMEM_LATENCY(g * 2)) dut (
         .clk      (clk),
         .rst      (rst_v[g]),
         .instr    (instr_v[g]),
         .Zero     (zero_v[g]),
         .PCSrc    (pcsrc[g]),
         .ALUSrc   (alusrc[g]),
         .RegWrite (regwr[g]),
         .MemToReg (m2r[g]),
         .ALUCtrl  (aluctrl[g]),
         .loadPC   (loadpc[g]),
         .MemRead  (memrd[g]),
         .MemWrite (memwr[g]),
         .illegal  (illg[g])
      );
   end

   localparam logic [11:0] M_PCS = 12'h800;
   localparam logic [11:0] M_RW  = 12'h200;
   localparam logic [11:0] M_M2R = 12'h100;
   localparam logic [11:0] M_LPC = 12'h008;
   localparam logic [11:0] M_MR  = 12'h004;
   localparam logic [11:0] M_MW  = 12'h002;
   localparam logic [11:0] M_ILL = 12'h001;

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;

   int n_cmp = 0;
   int n_err = 0;
   logic [11:0] exp_q[$];

   typedef struct {
      logic [31:0] in;
      logic        z;
      int          w;
      logic [4:0]  dec;
      string       nm;
   } vec_t;

   vec_t tbl[$];

   function automatic logic [11:0] obs(int w);
      return {pcsrc[w], alusrc[w], regwr[w], m2r[w], aluctrl[w],
              loadpc[w], memrd[w], memwr[w], illg[w]};
   endfunction

   function automatic logic [31:0] mk(logic [6:0] op, logic [2:0] f3,
                                      logic b30);
      logic [31:0] r;
      r = 32'h00208180;
      r[6:0] = op;
      r[14:12] = f3;
      r[30] = b30;
      return r;
   endfunction

   // reference decode: {ALUSrc, ALUCtrl}
   function automatic logic [4:0] ref_dec(logic [31:0] in);
      logic [3:0] t[8];
      logic [3:0] a;
      t = '{4'b0010, 4'b1001, 4'b0111, 4'b0010,
            4'b1101, 4'b1000, 4'b0001, 4'b0000};
      a = t[in[14:12]];
      if (in[14:12] == 3'b101 && in[30]) a = 4'b1010;
      case (in[6:0])
         OP_R: begin
            if (in[14:12] == 3'b000 && in[30]) a = 4'b0110;
            return {1'b0, a};
         end
         OP_I:   return {1'b1, a};
         OP_LW:  return {1'b1, 4'b0010};
         OP_SW:  return {1'b1, 4'b0010};
         OP_BEQ: return {1'b0, 4'b0110};
         default: return 5'b00000;
      endcase
   endfunction

   task automatic build(int w, logic [31:0] in, logic z, logic [4:0] dec);
      logic [11:0] b;
      int lat;
      lat = (w == 1) ? 2 : 0;
      b = 12'h000;
      b[10] = dec[4];
      b[7:4] = dec[3:0];
      exp_q.delete();
      exp_q.push_back(b);
      exp_q.push_back(b);
      case (in[6:0])
         OP_BEQ: exp_q.push_back(b | (z ? M_PCS : 12'h0) | M_LPC);
         OP_R, OP_I: begin
            exp_q.push_back(b);
            exp_q.push_back(b | M_RW | M_LPC);
         end
         OP_LW: begin
            exp_q.push_back(b);
            repeat (lat + 1) exp_q.push_back(b | M_MR | M_M2R);
            exp_q.push_back(b | M_RW | M_M2R | M_LPC);
         end
         OP_SW: begin
            exp_q.push_back(b);
            repeat (lat) exp_q.push_back(b);
            exp_q.push_back(b | M_MW | M_LPC);
         end
         default: begin
`ifdef ILLEGAL_TRAP_EN
            exp_q.push_back(b);
            repeat (4) exp_q.push_back(b | M_ILL);
`else
            exp_q.push_back(b | M_LPC);
`endif
         end
      endcase
   endtask

   task automatic check(int w, logic [11:0] e, string nm, int c);
      logic [11:0] g;
      g = obs(w);
      n_cmp++;
      if (g !== e) begin
         n_err++;
         $display("FAIL %s dut%0d cyc%0d got=%h exp=%h", nm, w, c, g, e);
      end
   endtask

   // runs one instruction from IF; stop_at >= 0 pulses rst in that cycle
   task automatic run(int w, logic [31:0] in, logic z, logic [4:0] dec,
                      int stop_at, string nm);
      build(w, in, z, dec);
      rst_v[1 - w] = 1'b1;
      rst_v[w] = 1'b0;
      instr_v[w] = in;
      zero_v[w] = z;
      for (int c = 0; c < exp_q.size(); c++) begin
         if (c == stop_at) begin
            rst_v[w] = 1'b1;
            @(negedge clk);
            check(w, 12'h000, {nm, "_rst"}, c);
            @(posedge clk);
            #1;
            rst_v[w] = 1'b0;
            return;
         end
         @(negedge clk);
         check(w, exp_q[c], nm, c);
         @(posedge clk);
         #1;
      end
`ifdef ILLEGAL_TRAP_EN
      if (dec == 5'b0 && ref_dec(in) == 5'b0 && in[6:0] != OP_R) begin
         rst_v[w] = 1'b1;
         @(posedge clk);
         #1;
         rst_v[w] = 1'b0;
      end
`endif
   endtask

   initial begin
      logic [31:0] in;
      logic [6:0] ops[5];
      int k;
      ops = '{OP_R, OP_I, OP_LW, OP_SW, OP_BEQ};

      tbl.push_back('{32'h002081B3, 1'b0, 0, 5'b0_0010, "add"});
      tbl.push_back('{32'h00208463, 1'b1, 0, 5'b0_0110, "beq_t"});
      tbl.push_back('{32'h00208463, 1'b0, 0, 5'b0_0110, "beq_n"});
      tbl.push_back('{32'h0040A283, 1'b0, 1, 5'b1_0010, "lw_l2"});
      tbl.push_back('{32'h0050A423, 1'b0, 0, 5'b1_0010, "sw_l0"});
      tbl.push_back('{32'h40325213, 1'b0, 0, 5'b1_1010, "srai"});
      tbl.push_back('{32'h403100B3, 1'b0, 0, 5'b0_0110, "sub"});
      tbl.push_back('{mk(OP_R, 3'b111, 1'b0), 1'b0, 0, 5'b0_0000, "and"});
      tbl.push_back('{mk(OP_R, 3'b110, 1'b0), 1'b0, 0, 5'b0_0001, "or"});
      tbl.push_back('{mk(OP_R, 3'b100, 1'b0), 1'b0, 0, 5'b0_1101, "xor"});
      tbl.push_back('{mk(OP_R, 3'b010, 1'b0), 1'b0, 0, 5'b0_0111, "slt"});
      tbl.push_back('{mk(OP_R, 3'b001, 1'b0), 1'b0, 0, 5'b0_1001, "sll"});
      tbl.push_back('{mk(OP_R, 3'b101, 1'b0), 1'b0, 0, 5'b0_1000, "srl"});
      tbl.push_back('{mk(OP_R, 3'b101, 1'b1), 1'b0, 0, 5'b0_1010, "sra"});
      tbl.push_back('{mk(OP_I, 3'b000, 1'b1), 1'b0, 0, 5'b1_0010, "addi30"});
      tbl.push_back('{mk(OP_I, 3'b110, 1'b0), 1'b0, 0, 5'b1_0001, "ori"});
      tbl.push_back('{32'h0040A283, 1'b0, 0, 5'b1_0010, "lw_l0"});
      tbl.push_back('{32'h0050A423, 1'b0, 1, 5'b1_0010, "sw_l2"});
      tbl.push_back('{32'h00208463, 1'b1, 1, 5'b0_0110, "beq_t1"});
      tbl.push_back('{32'h0000007F, 1'b0, 0, 5'b0_0000, "ill"});
      tbl.push_back('{32'h002081B3, 1'b0, 0, 5'b0_0010, "add_after"});

      rst_v[0] = 1'b1;
      rst_v[1] = 1'b1;
      instr_v[0] = 32'h002081B3;
      instr_v[1] = 32'h0040A283;
      zero_v[0] = 1'b1;
      zero_v[1] = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check(0, 12'h000, "reset0", 0);
      check(1, 12'h000, "reset1", 0);
      @(posedge clk);
      #1;

      foreach (tbl[i])
         run(tbl[i].w, tbl[i].in, tbl[i].z, tbl[i].dec, -1, tbl[i].nm);

      run(0, 32'h40325213, 1'b0, 5'b1_1010, 2, "srai_rst");
      run(0, 32'h40325213, 1'b0, 5'b1_1010, -1, "srai_re");
      run(1, 32'h0040A283, 1'b0, 5'b1_0010, 4, "lw_rst");
      run(1, 32'h002081B3, 1'b0, 5'b0_0010, -1, "add_re1");
      run(1, 32'h0050A423, 1'b0, 5'b1_0010, 5, "sw_rst");
      run(1, 32'h0050A423, 1'b0, 5'b1_0010, -1, "sw_re1");

      for (int r = 0; r < 60; r++) begin
         in = $urandom;
`ifdef ILLEGAL_TRAP_EN
         k = $urandom_range(0, 4);
`else
         k = $urandom_range(0, 5);
`endif
         if (k < 5) begin
            in[6:0] = ops[k];
         end else begin
            while (in[6:0] == OP_R || in[6:0] == OP_I || in[6:0] == OP_LW ||
                   in[6:0] == OP_SW || in[6:0] == OP_BEQ)
               in[6:0] = 7'($urandom);
         end
         run($urandom_range(0, 1), in, 1'($urandom), ref_dec(in), -1, "rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle control FSM that drives the control inputs of the single-datapath RISC-V core: it steps each instruction through IF/ID/EX/MEM/WB and generates `PCSrc`, `ALUSrc`, `RegWrite`, `MemToReg`, `ALUCtrl`, `loadPC` and the data-memory strobes. It consumes `instr` (held stable by combinational instruction memory until `PC` updates) and the ALU `Zero` flag returned by the datapath. Supported subset: R-type, I-type ALU, LW, SW, BEQ.

## Interface
- `DMEM_LATENCY`, default 0: extra wait cycles spent in MEM before a load/store completes (0–15).
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `instr`  in  32  current instruction (opcode [6:0], funct3 [14:12], funct7 bit [30])
- `Zero`  in  1  ALU zero flag from datapath
- `PCSrc`  out  1  take branch offset on PC update
- `ALUSrc`  out  1  ALU op2 = immediate
- `RegWrite`  out  1  register-file write enable
- `MemToReg`  out  1  write-back selects `dReadData`
- `ALUCtrl`  out  4  ALU operation
- `loadPC`  out  1  PC update strobe (one cycle per instruction)
- `MemRead`  out  1  data-memory read strobe
- `MemWrite`  out  1  data-memory write strobe
- `illegal`  out  1  sticky illegal-opcode flag

## Operation
- Opcodes: R 0110011, I 0010011, LW 0000011, SW 0100011, BEQ 1100011; any other is illegal.
- ALUCtrl codes: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, SRL 1000, SLL 1001, SRA 1010, XOR 1101.
- R-type decode by funct3: 000 ADD (instr[30]=1 → SUB), 111 AND, 110 OR, 100 XOR, 010 SLT, 001 SLL, 101 SRL (instr[30]=1 → SRA).
- I-type: same table, except 000 is always ADD; 101 still uses instr[30].
- LW/SW → ADD, ALUSrc=1. BEQ → SUB, ALUSrc=0. R → ALUSrc=0. I → ALUSrc=1.
- `ALUCtrl`/`ALUSrc` are pure decode of `instr`, valid in every state except reset.
- States: IF → ID → EX; from EX: R/I → WB; LW/SW → MEM; BEQ → IF; illegal → see Configuration.
- MEM: wait counter loads `DMEM_LATENCY` on entry, decrements per cycle; leaves when 0. LW → WB; SW → IF.
- WB → IF.
- `MemRead`=1 in every MEM cycle of LW. `MemWrite`=1 only in the final MEM cycle of SW.
- `MemToReg`=1 in MEM and WB of LW, else 0.
- `RegWrite`=1 only in WB (one cycle).
- `loadPC`=1 in the last state of each instruction: WB (R/I/LW), final MEM cycle (SW), EX (BEQ).
- `PCSrc` = EX & BEQ & `Zero`; 0 elsewhere.

## Timing
- Reset: state=IF, counter=0, `illegal`=0; while `rst`=1 every output is 0 (gated combinationally).
- Cycles per instruction: BEQ 3; R/I 4; SW 4+DMEM_LATENCY; LW 5+DMEM_LATENCY.
- PC changes on the rising edge ending the `loadPC` cycle; the next cycle is IF of the new instruction.
- Never assert `RegWrite` and `MemWrite` in the same cycle; never more than one `loadPC` per instruction.
- Reset asserted mid-instruction (any state, incl. MEM wait): no pending write is issued; IF on the cycle after `rst` deasserts.
- `instr`/`Zero` sampled combinationally; no registered copies.

## Configuration
- `ILLEGAL_TRAP_EN` defined: illegal opcode in EX → HALT state; `illegal` set and held 1; all strobes 0, no `loadPC`; exits only via `rst`.
- Not defined: illegal opcode treated as NOP — EX asserts `loadPC` with `PCSrc`=0 (PC+4), returns to IF; `illegal` tied 0.

## Test plan
- `add x3,x1,x2` (0x002081B3), latency 0 → IF,ID,EX,WB; `ALUCtrl`=0010, `RegWrite`=1 and `loadPC`=1 only in cycle 4.
- `beq x1,x2,+8`, `Zero`=1 → `PCSrc`=1 and `loadPC`=1 in cycle 3; `Zero`=0 → `PCSrc`=0, `loadPC`=1 in cycle 3; `ALUCtrl`=0110.
- `lw x5,4(x1)`, DMEM_LATENCY=2 → MEM 3 cycles with `MemRead`=1, `MemToReg`=1; WB at cycle 7 with `RegWrite`=1, `loadPC`=1.
- `sw x5,8(x1)`, DMEM_LATENCY=0 → cycle 4: `MemWrite`=1, `loadPC`=1, `RegWrite`=0; `ALUSrc`=1, `ALUCtrl`=0010.
- `srai x4,x4,3` (instr[30]=1) → `ALUCtrl`=1010, `ALUSrc`=1; `rst` pulsed in its EX → no `RegWrite`, IF after release.
- Opcode 1111111: with `ILLEGAL_TRAP_EN`, `illegal`=1 held, no further `loadPC` until reset; without, `loadPC`=1 in cycle 3, `PCSrc`=0.
